// File: rtl/multiexp_sched_if.sv
// multiexp_sched_if: pair stream, per-core beat/result handshakes and final point of the multiexp scheduler
interface multiexp_sched_if #(
    parameter int NUM_CORES = 4,
    parameter int PNT_BITS  = 512,
    parameter int SCL_BITS  = 256,
    parameter int CTL_BITS  = 8
);
    localparam int DAT_BITS = PNT_BITS + SCL_BITS;
    logic [63:0]             i_num_in;
    logic                    i_val;
    logic                    o_rdy;
    logic [DAT_BITS-1:0]     i_dat;
    logic [NUM_CORES-1:0]    o_core_val;
    logic [NUM_CORES-1:0]    i_core_rdy;
    logic [DAT_BITS-1:0]     o_core_dat;
    logic [CTL_BITS-1:0]     o_core_ctl;
    logic [NUM_CORES*64-1:0] o_core_num_in;
    logic [NUM_CORES-1:0]    i_res_val;
    logic [NUM_CORES-1:0]    o_res_rdy;
    logic [NUM_CORES*PNT_BITS-1:0] i_res_dat;
    logic                    o_val;
    logic                    i_rdy;
    logic [PNT_BITS-1:0]     o_dat;
    modport slave (
        input  i_num_in, i_val, i_dat, i_core_rdy, i_res_val, i_res_dat, i_rdy,
        output o_rdy, o_core_val, o_core_dat, o_core_ctl, o_core_num_in, o_res_rdy, o_val, o_dat
    );
    modport master (
        output i_num_in, i_val, i_dat, i_core_rdy, i_res_val, i_res_dat, i_rdy,
        input  o_rdy, o_core_val, o_core_dat, o_core_ctl, o_core_num_in, o_res_rdy, o_val, o_dat
    );
endinterface

// File: rtl/multiexp_sched.sv
// multiexp_sched: deals pairs round-robin to the cores, folds their partial sums through core 0; MULTIEXP_SCHED_PERF_EN adds o_stall_cnt
module multiexp_sched #(
    parameter int NUM_CORES = 4,
    parameter int PNT_BITS  = 512,
    parameter int SCL_BITS  = 256,
    parameter int KEY_BITS  = 256,
    parameter int CTL_BITS  = 8
) (
    input logic i_clk,
    input logic i_rst,
    multiexp_sched_if.slave bus
`ifdef MULTIEXP_SCHED_PERF_EN
    , output logic [31:0] o_stall_cnt
`endif
);
    localparam int CW = $clog2(NUM_CORES);
    typedef enum logic [2:0] {IDLE, DIST, COLLAPSE_SEND, COLLAPSE_WAIT, OUT} state_t;
    state_t state, nxt;
    logic [63:0] num, idx, beat;
    logic [CW-1:0] sel, k, last, last_calc;
    logic [NUM_CORES-1:0] act, act_calc, done, res_take;
    logic [PNT_BITS-1:0] res_buf [NUM_CORES];
    logic [NUM_CORES*64-1:0] core_num, num_calc;
    logic [71:0] total;
    logic all_sent, fire_up, wrap;

    // per-core share ceil((N-c)/NUM_CORES) of a newly requested run, written so large N cannot overflow
    always_comb begin
        num_calc = '0;
        act_calc = '0;
        for (int c = 0; c < NUM_CORES; c++) begin
            act_calc[c] = bus.i_num_in > 64'(c);
            num_calc[c*64 +: 64] = act_calc[c] ? (bus.i_num_in - 64'(c) - 64'd1) / 64'(NUM_CORES) + 64'd1 : 64'd0;
        end
        last_calc = bus.i_num_in >= 64'(NUM_CORES) ? CW'(NUM_CORES - 1) : CW'(bus.i_num_in) - CW'(1);
    end

    assign total    = 72'(num) * 72'(KEY_BITS);
    assign all_sent = 72'(beat) == total;
    assign fire_up  = state == DIST && bus.i_val && bus.o_rdy;
    assign wrap     = idx == num - 64'd1;
    assign res_take = bus.i_res_val & bus.o_res_rdy;
    assign bus.o_core_num_in = core_num;

    // state register
    always_ff @(posedge i_clk) begin
        state <= i_rst ? IDLE : nxt;
    end

    // next state and handshake outputs; dealing path is combinational from the upstream stream
    always_comb begin
        nxt = state;
        bus.o_rdy = 1'b0;
        bus.o_core_val = '0;
        bus.o_core_dat = '0;
        bus.o_core_ctl = '0;
        bus.o_res_rdy = '0;
        bus.o_val = 1'b0;
        bus.o_dat = '0;
        case (state)
            IDLE: if (bus.i_val) nxt = bus.i_num_in == 64'd0 ? OUT : DIST;
            DIST: begin
                bus.o_rdy = bus.i_core_rdy[sel] && !all_sent;
                bus.o_core_val[sel] = bus.i_val && !all_sent;
                bus.o_core_dat = bus.i_dat;
                bus.o_res_rdy = act & ~done;
                if (all_sent && done == act) nxt = last == '0 ? OUT : COLLAPSE_SEND;
            end
            COLLAPSE_SEND: begin
                bus.o_core_val[0] = 1'b1;
                bus.o_core_ctl = CTL_BITS'(1);
                bus.o_core_dat = {res_buf[k], SCL_BITS'(0)};
                if (bus.i_core_rdy[0]) nxt = COLLAPSE_WAIT;
            end
            COLLAPSE_WAIT: begin
                bus.o_res_rdy[0] = 1'b1;
                if (bus.i_res_val[0]) nxt = k == last ? OUT : COLLAPSE_SEND;
            end
            OUT: begin
                bus.o_val = 1'b1;
                bus.o_dat = res_buf[0];
                if (bus.i_rdy) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    // run bookkeeping: latch the request, advance dealing, capture partial sums, step the fold through core 0
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            num <= '0;
            idx <= '0;
            beat <= '0;
            sel <= '0;
            k <= '0;
            last <= '0;
            act <= '0;
            done <= '0;
            core_num <= '0;
            for (int c = 0; c < NUM_CORES; c++) res_buf[c] <= '0;
        end else begin
            if (state == IDLE && bus.i_val) begin
                num <= bus.i_num_in;
                idx <= '0;
                beat <= '0;
                sel <= '0;
                k <= '0;
                last <= last_calc;
                act <= act_calc;
                done <= '0;
                core_num <= num_calc;
                for (int c = 0; c < NUM_CORES; c++) res_buf[c] <= '0;
            end
            if (fire_up) begin
                beat <= beat + 64'd1;
                idx <= wrap ? '0 : idx + 64'd1;
                sel <= wrap || sel == CW'(NUM_CORES - 1) ? '0 : sel + CW'(1);
            end
            if (state == DIST) begin
                done <= done | res_take;
                for (int c = 0; c < NUM_CORES; c++)
                    if (res_take[c]) res_buf[c] <= bus.i_res_dat[c*PNT_BITS +: PNT_BITS];
            end
            if (state == DIST && nxt == COLLAPSE_SEND) begin
                k <= CW'(1);
                core_num[63:0] <= 64'd1;
            end
            if (state == COLLAPSE_WAIT && bus.i_res_val[0]) begin
                res_buf[0] <= bus.i_res_dat[PNT_BITS-1:0];
                k <= k + CW'(1);
            end
        end
    end

`ifdef MULTIEXP_SCHED_PERF_EN
    // upstream stall cycles while dealing, saturating, cleared as each run starts dealing
    always_ff @(posedge i_clk) begin
        if (i_rst || (state == IDLE && nxt == DIST)) o_stall_cnt <= '0;
        else if (state == DIST && bus.i_val && !bus.o_rdy && o_stall_cnt != '1) o_stall_cnt <= o_stall_cnt + 32'd1;
    end
`endif
endmodule

// File: tb/tb_multiexp_sched.sv
// tb_multiexp_sched: randomized scenarios against behavioural core models and a closed-form result model
module tb_multiexp_sched;
    localparam int NC = 4, PB = 32, SB = 16, KB = 4, CB = 8, DB = PB + SB;
    localparam int OW = 1 + NC + CB + DB + NC*64 + NC + 1 + PB;
    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;

    multiexp_sched_if #(.NUM_CORES(NC), .PNT_BITS(PB), .SCL_BITS(SB), .CTL_BITS(CB)) bus();
`ifdef MULTIEXP_SCHED_PERF_EN
    logic [31:0] stall_cnt;
`endif
    multiexp_sched #(.NUM_CORES(NC), .PNT_BITS(PB), .SCL_BITS(SB), .KEY_BITS(KB), .CTL_BITS(CB)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus(bus)
`ifdef MULTIEXP_SCHED_PERF_EN
        , .o_stall_cnt(stall_cnt)
`endif
    );

    int vectors = 0, miscompares = 0;
    int beats, misroute, sends, bad_send, final_cnt, stall_seen, stall_bad, max_cap;
    bit timeout, num_snapped;
    logic [NC*64-1:0] num_snap;
    logic [NC-1:0] val_seen;
    logic [PB-1:0] final_dat;
    logic [31:0] stall_obs;
    logic [OW-1:0] outs;
    int order[$];
    logic [DB-1:0] pairs [64];

    function automatic logic [OW-1:0] all_outs();
        return {bus.o_rdy, bus.o_core_val, bus.o_core_ctl, bus.o_core_dat, bus.o_core_num_in, bus.o_res_rdy, bus.o_val, bus.o_dat};
    endfunction

    // closed form: every pair passes KB times and each pass adds point+scalar once
    function automatic logic [PB-1:0] model_sum(input int n);
        logic [PB-1:0] s = '0;
        for (int i = 0; i < n; i++) s += pairs[i][DB-1:SB] + PB'(pairs[i][SB-1:0]);
        return s * PB'(KB);
    endfunction

    function automatic logic [NC*64-1:0] model_num(input int n);
        logic [NC*64-1:0] r = '0;
        for (int c = 0; c < NC; c++) r[c*64 +: 64] = n > c ? 64'((n - c + NC - 1) / NC) : 64'd0;
        return r;
    endfunction

    task automatic run_op(input int n, input bit rnd, input int stall_len, input bit hold, input bit abort);
        int up_idx = 0, cap;
        logic [PB-1:0] acc [NC], part [NC];
        int rcv [NC], need [NC];
        bit pend [NC], given [NC];
        bit coll_pend = 0, fin = 0, do_abort = 0, coll = 0, taken = 0, exited = 0, fire, all_rcv;
        logic [NC-1:0] r;
        logic [PB-1:0] pt;
        beats = 0; misroute = 0; sends = 0; bad_send = 0; final_cnt = 0; stall_seen = 0; stall_bad = 0;
        max_cap = 0; timeout = 0; num_snapped = 0; num_snap = '0; val_seen = '0; final_dat = '0;
        stall_obs = '0; outs = '0; order.delete();
        for (int i = 0; i < 64; i++) pairs[i] = {PB'($urandom), SB'($urandom)};
        for (int c = 0; c < NC; c++) begin
            acc[c] = '0; part[c] = '0; rcv[c] = 0; pend[c] = 0; given[c] = 0;
            need[c] = n > c ? ((n - c - 1) / NC + 1) * KB : 0;
        end
        @(posedge clk) #1;
        bus.i_num_in = 64'(n);
        bus.i_val = 1'b1;
        bus.i_dat = pairs[0];
        bus.i_rdy = 1'b1;
        bus.i_core_rdy = stall_len > 0 ? NC'(4'b1011) : '1;
        bus.i_res_val = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            fire = bus.i_val && bus.o_rdy;
            val_seen |= bus.o_core_val;
`ifdef MULTIEXP_SCHED_PERF_EN
            if (stall_len > 0 && stall_seen == stall_len && !taken) begin stall_obs = stall_cnt; taken = 1; end
`endif
            if (stall_len > 0 && bus.o_core_val[2] && !bus.i_core_rdy[2]) begin
                stall_seen++;
                if (bus.o_rdy || (bus.o_core_val & NC'(4'b1011)) != '0) stall_bad++;
            end
            for (int c = 0; c < NC; c++) if (bus.o_core_val[c] && bus.i_core_rdy[c]) begin
                if (!bus.o_core_ctl[0]) begin
                    if (!num_snapped) begin num_snap = bus.o_core_num_in; num_snapped = 1; end
                    if (n == 0 || c != (beats % n) % NC || bus.o_core_dat !== pairs[beats % n]) misroute++;
                    acc[c] += bus.o_core_dat[DB-1:SB] + PB'(bus.o_core_dat[SB-1:0]);
                    rcv[c]++;
                    beats++;
                end else begin
                    sends++;
                    coll = 1;
                    pt = bus.o_core_dat[DB-1:SB];
                    if (c != 0 || bus.o_core_num_in[63:0] !== 64'd1 || bus.o_core_dat[SB-1:0] !== '0) bad_send++;
                    for (int j = 1; j < NC; j++) if (part[j] === pt) begin order.push_back(j); break; end
                    acc[0] += pt;
                    coll_pend = 1;
                    if (abort) do_abort = 1;
                end
            end
            cap = 0;
            for (int c = 0; c < NC; c++) if (bus.i_res_val[c] && bus.o_res_rdy[c]) begin
                cap++;
                pend[c] = 0;
                if (!coll) part[c] = acc[c];
            end
            if (cap > max_cap) max_cap = cap;
            if (bus.o_val) begin final_cnt++; final_dat = bus.o_dat; fin = 1; end
            @(posedge clk) #1;
            if (do_abort) begin
                rst = 1'b1;
                bus.i_val = 1'b0; bus.i_core_rdy = '0; bus.i_res_val = '0; bus.i_rdy = 1'b0;
                @(posedge clk);
                @(negedge clk);
                outs = all_outs();
                @(posedge clk) #1;
                rst = 1'b0;
                exited = 1;
                break;
            end
            if (fin) begin
                bus.i_val = 1'b0;
                bus.i_res_val = '0;
                exited = 1;
                break;
            end
            if (fire && n > 0) begin up_idx = (up_idx + 1) % n; bus.i_dat = pairs[up_idx]; end
            r = rnd ? NC'($urandom) : '1;
            if (stall_len > 0 && stall_seen < stall_len) r[2] = 1'b0;
            bus.i_core_rdy = r;
            all_rcv = 1;
            for (int c = 0; c < NC; c++) if (rcv[c] != need[c]) all_rcv = 0;
            for (int c = 0; c < NC; c++)
                if (!given[c] && need[c] > 0 && rcv[c] == need[c] && (!hold || all_rcv)) begin pend[c] = 1; given[c] = 1; end
            if (coll_pend) begin pend[0] = 1; coll_pend = 0; end
            for (int c = 0; c < NC; c++) begin
                bus.i_res_val[c] = pend[c];
                bus.i_res_dat[c*PB +: PB] = acc[c];
            end
        end
        if (!exited) begin
            timeout = 1;
            bus.i_val = 1'b0;
            bus.i_res_val = '0;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (all_outs() !== '0) begin miscompares++; $display("FAIL reset_outputs got %h want 0", all_outs()); end
        @(posedge clk) #1;
        rst = 1'b0;
    endtask

    task automatic test_full;
        run_op(8, 0, 0, 0, 0);
        vectors++; if (timeout) begin miscompares++; $display("FAIL full_timeout got 1 want 0"); end
        vectors++; if (num_snap !== model_num(8)) begin miscompares++; $display("FAIL full_num_in got %h want %h", num_snap, model_num(8)); end
        vectors++; if (beats != 8 * KB || misroute != 0) begin miscompares++; $display("FAIL full_deal beats %0d misrouted %0d want %0d/0", beats, misroute, 8 * KB); end
        vectors++; if (sends != 3 || bad_send != 0) begin miscompares++; $display("FAIL full_collapse sends %0d bad %0d want 3/0", sends, bad_send); end
        vectors++; if (final_cnt != 1 || final_dat !== model_sum(8)) begin miscompares++; $display("FAIL full_result got %h x%0d want %h x1", final_dat, final_cnt, model_sum(8)); end
    endtask

    task automatic test_partial;
        run_op(3, 0, 0, 0, 0);
        vectors++; if (num_snap !== model_num(3)) begin miscompares++; $display("FAIL partial_num_in got %h want %h", num_snap, model_num(3)); end
        vectors++; if (val_seen[3] !== 1'b0) begin miscompares++; $display("FAIL partial_core3_idle got %b want 0", val_seen[3]); end
        vectors++; if (misroute != 0 || sends != 2 || bad_send != 0) begin miscompares++; $display("FAIL partial_traffic misrouted %0d sends %0d bad %0d want 0/2/0", misroute, sends, bad_send); end
        vectors++; if (final_cnt != 1 || final_dat !== model_sum(3)) begin miscompares++; $display("FAIL partial_result got %h x%0d want %h x1", final_dat, final_cnt, model_sum(3)); end
    endtask

    task automatic test_zero;
        run_op(0, 0, 0, 0, 0);
        vectors++; if (val_seen !== '0 || beats != 0) begin miscompares++; $display("FAIL zero_traffic got %b/%0d want 0/0", val_seen, beats); end
        vectors++; if (timeout || final_cnt != 1 || final_dat !== '0) begin miscompares++; $display("FAIL zero_result got %h x%0d want 0 x1", final_dat, final_cnt); end
    endtask

    task automatic test_stall;
        run_op(8, 0, 50, 0, 0);
        vectors++; if (stall_seen != 50 || stall_bad != 0) begin miscompares++; $display("FAIL stall_hold seen %0d leaks %0d want 50/0", stall_seen, stall_bad); end
`ifdef MULTIEXP_SCHED_PERF_EN
        vectors++; if (stall_obs !== 32'd50) begin miscompares++; $display("FAIL stall_cnt got %0d want 50", stall_obs); end
`endif
        vectors++; if (misroute != 0 || final_cnt != 1 || final_dat !== model_sum(8)) begin miscompares++; $display("FAIL stall_result got %h x%0d misrouted %0d want %h", final_dat, final_cnt, misroute, model_sum(8)); end
    endtask

    task automatic test_simul;
        bit ok;
        run_op(4, 0, 0, 1, 0);
        vectors++; if (max_cap != 4) begin miscompares++; $display("FAIL simul_capture got %0d want 4", max_cap); end
        ok = order.size() == 3;
        for (int i = 0; i < order.size(); i++) if (order[i] != i + 1) ok = 0;
        vectors++; if (!ok) begin miscompares++; $display("FAIL simul_order got %0d sends in wrong order want 1,2,3", order.size()); end
        vectors++; if (final_cnt != 1 || final_dat !== model_sum(4)) begin miscompares++; $display("FAIL simul_result got %h want %h", final_dat, model_sum(4)); end
    endtask

    task automatic test_abort;
        run_op(8, 0, 0, 0, 1);
        vectors++; if (outs !== '0 || final_cnt != 0) begin miscompares++; $display("FAIL abort_outputs got %h x%0d want 0 x0", outs, final_cnt); end
        run_op(4, 0, 0, 0, 0);
        vectors++; if (timeout || sends != 3 || final_cnt != 1 || final_dat !== model_sum(4)) begin miscompares++; $display("FAIL abort_rerun got %h sends %0d want %h sends 3", final_dat, sends, model_sum(4)); end
    endtask

    task automatic test_back_to_back;
        int n;
        bit ok;
        for (int t = 0; t < 5; t++) begin
            n = $urandom_range(1, 11);
            run_op(n, 1, 0, 0, 0);
            ok = order.size() == (n < NC ? n : NC) - 1;
            for (int i = 0; i < order.size(); i++) if (order[i] != i + 1) ok = 0;
            vectors++; if (timeout || misroute != 0 || beats != n * KB) begin miscompares++; $display("FAIL rand_deal n=%0d beats %0d misrouted %0d timeout %0b", n, beats, misroute, timeout); end
            vectors++; if (!ok || bad_send != 0) begin miscompares++; $display("FAIL rand_collapse n=%0d sends %0d bad %0d", n, sends, bad_send); end
            vectors++; if (final_cnt != 1 || final_dat !== model_sum(n)) begin miscompares++; $display("FAIL rand_result n=%0d got %h want %h", n, final_dat, model_sum(n)); end
        end
    endtask

    initial begin
        bus.i_num_in = '0; bus.i_val = 1'b0; bus.i_dat = '0; bus.i_core_rdy = '0;
        bus.i_res_val = '0; bus.i_res_dat = '0; bus.i_rdy = 1'b0;
        test_reset;
        test_full;
        test_partial;
        test_zero;
        test_stall;
        test_simul;
        test_abort;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/multiexp_sched.md
Name: multiexp_sched

Overview:
- Scheduler in front of NUM_CORES multiexp_core instances.
- Deals the looping scalar/point pair stream round-robin across the cores, one pair per beat, and collects one partial-sum point per core.
- Collapses the partial sums by replaying them into core 0 in single-add mode (ctl[0]=1), then emits one final point.

Parameters:
- NUM_CORES, 4, number of multiexp cores driven (≥2).
- PNT_BITS, 512, width of FP_TYPE point.
- SCL_BITS, 256, width of FE_TYPE scalar; pair width DAT_BITS = PNT_BITS+SCL_BITS, point in upper bits.
- KEY_BITS, 256, scalar bit count; number of passes over the input set.
- CTL_BITS, 8, core ctl width.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset
- i_num_in  in  64  total pair count N, sampled on start
- i_val / o_rdy / i_dat  in/out/in  1/1/DAT_BITS  upstream looping pair stream
- o_core_val  out  NUM_CORES  per-core beat valid
- i_core_rdy  in  NUM_CORES  per-core ready
- o_core_dat  out  DAT_BITS  shared beat data
- o_core_ctl  out  CTL_BITS  shared ctl; bit0 = single-add mode
- o_core_num_in  out  NUM_CORES*64  per-core pair count
- i_res_val / o_res_rdy  in/out  NUM_CORES each  core result handshake
- i_res_dat  in  NUM_CORES*PNT_BITS  core result points
- o_val / i_rdy / o_dat  out/in/out  1/1/PNT_BITS  final point

Behaviour:
- Reset is i_rst, synchronous, active-high, on clock i_clk.
- Reset values: all val/rdy outputs 0; o_core_dat, o_core_ctl, o_core_num_in, o_dat = 0; state IDLE; all counters 0.
- Handshake: a beat transfers on val&&rdy. Valid outputs hold data until accepted.
- IDLE: when i_val=1, latch N=i_num_in.
  - Per-core count n_c = ceil((N-c)/NUM_CORES). A core is active iff n_c>0.
  - Drive o_core_num_in from the n_c values; go to DIST next cycle.
  - N=0: go directly to OUT with o_dat=0.
- DIST: o_core_ctl=0. The beat goes to core sel.
  - o_core_val[sel]=i_val; o_rdy=i_core_rdy[sel]; o_core_dat=i_dat. This path is combinational, zero latency.
  - On each accepted beat: sel wraps at NUM_CORES; pair idx wraps at N (sel returns to 0 when idx wraps); beat count increments.
  - After N*KEY_BITS beats, o_rdy=0 and further upstream beats are not consumed.
  - Results: o_res_rdy[c]=1 for active cores not yet captured; capture i_res_dat[c] into res_buf[c] and set done[c].
  - Result capture runs in parallel with distribution.
  - Leave DIST when all beats are sent and done==active mask. Go to COLLAPSE_SEND with k=1; if only core 0 is active, go to OUT.
- COLLAPSE_SEND:
  - o_core_val[0]=1, o_core_ctl=1, o_core_dat={res_buf[k], SCL_BITS'0}, o_core_num_in[0]=1.
  - On accept, go to COLLAPSE_WAIT.
- COLLAPSE_WAIT:
  - o_res_rdy[0]=1; on i_res_val[0], res_buf[0]<=i_res_dat[0] and k++.
  - If k reaches the last active core, go to OUT; else go to COLLAPSE_SEND.
- OUT: o_val=1, o_dat=res_buf[0]; on i_rdy, go to IDLE.
- Simultaneous results from several cores in the same cycle are all captured.
- A result from an inactive or already-done core is not accepted (o_res_rdy=0).
- Reset mid-operation: abort immediately to reset values. No output is produced and buffered results are discarded.
- Counters are 64-bit; N*KEY_BITS uses 72-bit arithmetic.

Optional Feature:
- Macro MULTIEXP_SCHED_PERF_EN.
- Defined: adds output o_stall_cnt [31:0]. It counts DIST cycles with i_val=1 && o_rdy=0, clears on IDLE->DIST, and saturates at 2^32-1.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- NUM_CORES=4, KEY_BITS=4, N=8, all core_rdy=1 -> n=2,2,2,2; 32 beats dealt cyclically 0,1,2,3; then 3 collapse sends to core 0 with ctl=1; one final o_val.
- N=3 -> n=1,1,1,0; core 3 never sees o_core_val; two collapse sends; o_dat equals core-model sum of 3 points.
- N=0 -> one o_val beat with o_dat=0, no core traffic.
- Core 2 holds i_core_rdy=0 for 50 cycles in DIST -> upstream stalls (o_rdy=0) and no beat goes to any other core; with the macro defined, o_stall_cnt=50.
- Cores 0..3 assert i_res_val in the same cycle -> all four captured; collapse order is 1,2,3.
- i_rst asserted during COLLAPSE_WAIT -> all outputs 0 next cycle; a fresh N=4 run then completes correctly.
